run_control_timer: RTL and testbench

Parametrised, synthesizable run-length controller for the stm32F072 simulation and bring-up environment. It counts clk cycles from a start request up to a programmable limit and either ends the run (one-shot) or wraps and ticks (periodic). It supports pause, early termination on a core halt request, and reports why the run ended. It sits beside the core top level and drives bench-level finish logic, or an on-chip watchdog/LED heartbeat on hardware.

---
 rtl/run_control_timer.sv | 114 +++++++++++
 tb/tb_run_control_timer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/run_control_timer.sv
// run_control_timer: counts clk cycles from a run request up to a programmable
// limit. One-shot mode (MODE 0) ends the run at the limit. Periodic mode
// (MODE 1) wraps to zero and pulses tick.
// A halt request ends the run early, and cause records why the run ended.
// There is no valid/ready handshake. en is a level request: it is sampled on
// every rising edge. A finished run stays in DONE until en drops.
module run_control_timer #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned LIMIT = 55,
   parameter int unsigned MODE  = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             pause,
   input  logic             halt_req,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tick,
   output logic             done,
   output logic [1:0]       cause,
   output logic             running
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [1:0] CAUSE_NONE  = 2'b00;
   localparam logic [1:0] CAUSE_LIMIT = 2'b01;
   localparam logic [1:0] CAUSE_HALT  = 2'b10;

   localparam logic             PERIODIC    = (MODE != 0);
   localparam logic [WIDTH-1:0] LIMIT_RESET = WIDTH'(LIMIT);
   localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

   state_t           state;
   logic [WIDTH-1:0] limit_r;

   // running is a pure decode of the registered state, so it has no input path.
   assign running = (state == ST_RUN);

   // Run-control FSM: state, count, limit and the registered status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         count   <= '0;
         limit_r <= LIMIT_RESET;
         tick    <= 1'b0;
         done    <= 1'b0;
         cause   <= CAUSE_NONE;
      end else begin
         // tick is a single-cycle pulse; it is set again only on a wrap.
         tick <= 1'b0;
         case (state)
            ST_IDLE: begin
               count <= '0;
               done  <= 1'b0;
               cause <= CAUSE_NONE;
               // A load in the same cycle as en applies to the run being started.
               if (load) begin
                  limit_r <= load_val;
               end
               if (en) begin
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (halt_req) begin
                  // Halt wins over everything else, including pause and the limit.
                  state <= ST_DONE;
                  done  <= 1'b1;
                  cause <= CAUSE_HALT;
               end else if (!en) begin
                  state <= ST_IDLE;
                  count <= '0;
                  cause <= CAUSE_NONE;
               end else if (pause) begin
                  count <= count;
               end else if (count < limit_r) begin
                  count <= count + ONE;
               end else if (PERIODIC) begin
                  count <= '0;
                  tick  <= 1'b1;
               end else begin
                  // count stays at limit_r, so all-ones never wraps past itself.
                  state <= ST_DONE;
                  done  <= 1'b1;
                  cause <= CAUSE_LIMIT;
               end
            end
            ST_DONE: begin
               // Results are held until en drops; halt_req and pause have no effect.
               if (!en) begin
                  state <= ST_IDLE;
                  done  <= 1'b0;
                  cause <= CAUSE_NONE;
                  count <= '0;
               end
            end
            default: begin
               state <= ST_IDLE;
               count <= '0;
               done  <= 1'b0;
               cause <= CAUSE_NONE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_run_control_timer.sv
// Testbench for run_control_timer. Three instances share the same stimulus:
//   u0: WIDTH 8, MODE 0 (one-shot)
//   u1: WIDTH 8, MODE 1 (periodic)
//   u2: WIDTH 4, LIMIT 15, MODE 0
// Each scenario starts from reset and checks only the instance it targets.
module tb_run_control_timer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       pause = 1'b0;
   logic       halt_req = 1'b0;
   logic       load = 1'b0;
   logic [7:0] load_val = 8'd0;
   logic [3:0] load_val4;

   logic [7:0] u0_count, u1_count;
   logic [3:0] u2_count;
   logic       u0_tick, u1_tick, u2_tick;
   logic       u0_done, u1_done, u2_done;
   logic [1:0] u0_cause, u1_cause, u2_cause;
   logic       u0_running, u1_running, u2_running;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_c;
   int edges;

   assign load_val4 = load_val[3:0];

   run_control_timer #(.WIDTH(8), .LIMIT(55), .MODE(0)) u0 (
      .clk(clk), .rst(rst), .en(en), .pause(pause), .halt_req(halt_req),
      .load(load), .load_val(load_val), .count(u0_count), .tick(u0_tick),
      .done(u0_done), .cause(u0_cause), .running(u0_running));

   run_control_timer #(.WIDTH(8), .LIMIT(55), .MODE(1)) u1 (
      .clk(clk), .rst(rst), .en(en), .pause(pause), .halt_req(halt_req),
      .load(load), .load_val(load_val), .count(u1_count), .tick(u1_tick),
      .done(u1_done), .cause(u1_cause), .running(u1_running));

   run_control_timer #(.WIDTH(4), .LIMIT(15), .MODE(0)) u2 (
      .clk(clk), .rst(rst), .en(en), .pause(pause), .halt_req(halt_req),
      .load(load), .load_val(load_val4), .count(u2_count), .tick(u2_tick),
      .done(u2_done), .cause(u2_cause), .running(u2_running));

   // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   task automatic check(input string tag, input int observed, input int expected);
      n_cmp++;
      if (observed !== expected) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // One rising edge; inputs change and outputs are sampled 1 unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      en = 1'b0; pause = 1'b0; halt_req = 1'b0; load = 1'b0; load_val = 8'd0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   // Run u0 until done rises (bounded); edges counts from the edge after RUN entry.
   task automatic run_to_done(output int e);
      e = -1;
      for (int i = 1; i <= 80; i++) begin
         step();
         if (u0_done) begin
            e = i;
            break;
         end
      end
   endtask

   initial begin
      // Reset values.
      do_reset();
      check("rst_count", u0_count, 0);
      check("rst_done", u0_done, 0);
      check("rst_cause", u0_cause, 0);
      check("rst_running", u0_running, 0);
      check("rst_tick", u1_tick, 0);

      // One-shot, LIMIT 55: count 1..55, done 56 edges after RUN entry.
      en = 1'b1;
      step();
      check("os_entry_running", u0_running, 1);
      check("os_entry_count", u0_count, 0);
      for (int k = 1; k <= 55; k++) begin
         step();
         check("os_count", u0_count, k);
         check("os_not_done", u0_done, 0);
      end
      step();
      check("os_done", u0_done, 1);
      check("os_cause", u0_cause, 1);
      check("os_hold_count", u0_count, 55);
      check("os_running_low", u0_running, 0);
      step();
      check("os_sticky", u0_done, 1);
      en = 1'b0;
      step();
      check("os_idle_done", u0_done, 0);
      check("os_idle_count", u0_count, 0);
      check("os_idle_cause", u0_cause, 0);

      // Periodic, limit 3 loaded in IDLE: 1,2,3,0,... tick on each 0.
      do_reset();
      load = 1'b1; load_val = 8'd3;
      step();
      load = 1'b0;
      en = 1'b1;
      step();
      check("per_entry_tick", u1_tick, 0);
      check("per_entry_count", u1_count, 0);
      for (int r = 0; r < 2; r++) begin
         exp_q.push_back(8'd1);
         exp_q.push_back(8'd2);
         exp_q.push_back(8'd3);
         exp_q.push_back(8'd0);
      end
      while (exp_q.size() > 0) begin
         exp_c = exp_q.pop_front();
         step();
         check("per_count", u1_count, exp_c);
         check("per_tick", u1_tick, (exp_c == 8'd0) ? 1 : 0);
         check("per_no_done", u1_done, 0);
      end
      en = 1'b0;
      step();
      check("per_idle_tick", u1_tick, 0);

      // One-shot, limit 10, pause on edges 6..10: done at edge 16.
      do_reset();
      load = 1'b1; load_val = 8'd10;
      step();
      load = 1'b0;
      en = 1'b1;
      step();
      edges = -1;
      for (int i = 1; i <= 30; i++) begin
         pause = (i >= 6 && i <= 10);
         step();
         if (i == 8) check("pause_hold", u0_count, 5);
         if (u0_done) begin
            edges = i;
            break;
         end
      end
      pause = 1'b0;
      check("pause_done_edge", edges, 16);
      check("pause_final_count", u0_count, 10);

      // halt_req with pause at count 20; load in DONE is ignored.
      do_reset();
      en = 1'b1;
      step();
      for (int k = 1; k <= 20; k++) step();
      check("halt_pre_count", u0_count, 20);
      halt_req = 1'b1; pause = 1'b1;
      step();
      halt_req = 1'b0; pause = 1'b0;
      check("halt_done", u0_done, 1);
      check("halt_cause", u0_cause, 2);
      check("halt_count", u0_count, 20);
      check("halt_running", u0_running, 0);
      load = 1'b1; load_val = 8'd7;
      step();
      load = 1'b0;
      check("halt_load_ignored_count", u0_count, 20);
      en = 1'b0;
      step();
      en = 1'b1;
      step();
      run_to_done(edges);
      check("halt_limit_unchanged", edges, 56);
      en = 1'b0;

      // Async reset mid-run: outputs clear before the next edge, limit back to 55.
      do_reset();
      load = 1'b1; load_val = 8'd9;
      step();
      load = 1'b0;
      en = 1'b1;
      step();
      for (int k = 1; k <= 4; k++) step();
      check("arst_pre_count", u0_count, 4);
      #2;
      rst = 1'b1;
      #1;
      check("arst_count", u0_count, 0);
      check("arst_running", u0_running, 0);
      check("arst_done", u0_done, 0);
      en = 1'b0;
      #1;
      rst = 1'b0;
      step();
      en = 1'b1;
      step();
      run_to_done(edges);
      check("arst_limit_reload", edges, 56);
      check("arst_limit_cause", u0_cause, 1);
      en = 1'b0;

      // Limit 0: one-shot done at first RUN edge; periodic ticks every cycle.
      do_reset();
      load = 1'b1; load_val = 8'd0;
      step();
      load = 1'b0;
      en = 1'b1;
      step();
      check("lim0_entry_tick", u1_tick, 0);
      check("lim0_os_not_done", u0_done, 0);
      step();
      check("lim0_os_done", u0_done, 1);
      check("lim0_os_cause", u0_cause, 1);
      check("lim0_os_count", u0_count, 0);
      for (int k = 0; k < 3; k++) begin
         check("lim0_per_tick", u1_tick, 1);
         check("lim0_per_count", u1_count, 0);
         check("lim0_per_running", u1_running, 1);
         step();
      end
      en = 1'b0;

      // WIDTH 4, limit 15: reaches all-ones without wrapping, then DONE.
      do_reset();
      en = 1'b1;
      step();
      for (int k = 1; k <= 15; k++) begin
         step();
         check("w4_count", u2_count, k);
      end
      check("w4_not_done", u2_done, 0);
      step();
      check("w4_done", u2_done, 1);
      check("w4_cause", u2_cause, 1);
      check("w4_hold", u2_count, 15);
      en = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
